dmem_sram_bridge: RTL

DMEM_SRAM_BRIDGE -- requirements
Module: dmem_sram_bridge

---
 rtl/dmem_sram_bridge.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/dmem_sram_bridge.sv
// M-stage data memory to SRAM-like bus bridge: one access in flight, pipeline
// stalled until the bus responds, aborted with mem_err on a wait timeout.
module dmem_sram_bridge #(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_en,
  input  logic [3:0]  mem_wen,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  output logic [31:0] mem_rdata,
  output logic        mem_stall,
  output logic        mem_err,
  output logic        bus_req,
  output logic        bus_wr,
  output logic [1:0]  bus_size,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  input  logic        bus_addr_ok,
  input  logic        bus_data_ok,
  input  logic [31:0] bus_rdata
);

  // state  | meaning
  // IDLE   | waiting for a valid M-stage access
  // REQ    | request on the bus, waiting for addr_ok
  // RESP   | request accepted, waiting for data_ok
  // DONE   | pipeline-advance cycle, access retired (or aborted)
  typedef enum logic [1:0] {S_IDLE, S_REQ, S_RESP, S_DONE} state_t;

  localparam logic [8:0] LP_TIMEOUT = 9'(TIMEOUT);

  state_t      r_state;
  state_t      w_next;
  logic [7:0]  r_cnt;
  logic        r_wr;
  logic [1:0]  r_size;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [31:0] r_rdata;
  logic        r_err;

  logic        w_legal;
  logic        w_wr;
  logic [1:0]  w_size;
  logic [31:0] w_addr;
  logic [8:0]  w_cnt_inc;
  logic        w_timeout;
  logic        w_capture;
  logic        w_err_set;
  logic        w_abort;
  logic        w_load;

  always_comb begin
    w_legal = 1'b1;
    w_wr    = 1'b1;
    w_size  = 2'd2;
    w_addr  = mem_addr;
    case (mem_wen)
      4'b0000: begin
        w_wr   = 1'b0;
        w_addr = {mem_addr[31:2], 2'b00};
      end
      4'b0001, 4'b0010, 4'b0100, 4'b1000: w_size = 2'd0;
      4'b0011, 4'b1100:                   w_size = 2'd1;
      4'b1111:                            w_size = 2'd2;
      default: begin
        w_legal = 1'b0;
        w_wr    = 1'b0;
      end
    endcase
  end

  // The counter is cleared on entry, so it equals cycles already spent here.
  assign w_cnt_inc = {1'b0, r_cnt} + 9'd1;
  assign w_timeout = (w_cnt_inc == LP_TIMEOUT);

  always_comb begin
    w_next    = r_state;
    w_capture = 1'b0;
    w_err_set = 1'b0;
    w_abort   = 1'b0;
    w_load    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (mem_en) begin
          if (w_legal) begin
            w_capture = 1'b1;
            w_next    = S_REQ;
          end else begin
            w_err_set = 1'b1;
            w_next    = S_DONE;
          end
        end
      end
      S_REQ: begin
        if (bus_addr_ok) begin
          w_next = S_RESP;
        end else if (w_timeout) begin
          w_abort   = 1'b1;
          w_err_set = 1'b1;
          w_next    = S_DONE;
        end
      end
      S_RESP: begin
        if (bus_data_ok) begin
          w_load = ~r_wr;
          w_next = S_DONE;
        end else if (w_timeout) begin
          w_abort   = 1'b1;
          w_err_set = 1'b1;
          w_next    = S_DONE;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_cnt   <= 8'd0;
    end else begin
      r_state <= w_next;
      if (w_next != r_state) begin
        r_cnt <= 8'd0;
      end else if (r_state == S_REQ || r_state == S_RESP) begin
        r_cnt <= r_cnt + 8'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr    <= 1'b0;
      r_size  <= 2'd0;
      r_addr  <= 32'd0;
      r_wdata <= 32'd0;
      r_rdata <= 32'd0;
      r_err   <= 1'b0;
    end else begin
      if (w_capture) begin
        r_wr    <= w_wr;
        r_size  <= w_size;
        r_addr  <= w_addr;
        r_wdata <= mem_wdata;
      end
      if (w_abort) begin
        r_rdata <= 32'd0;
      end else if (w_load) begin
        r_rdata <= bus_rdata;
      end
      r_err <= w_err_set;
    end
  end

  assign bus_req   = (r_state == S_REQ);
  assign bus_wr    = r_wr;
  assign bus_size  = r_size;
  assign bus_addr  = r_addr;
  assign bus_wdata = r_wdata;
  assign mem_rdata = r_rdata;
  assign mem_err   = r_err;

  // Gated with rst so a held mem_en cannot stall the pipeline during reset.
  assign mem_stall = rst & (((r_state == S_IDLE) & mem_en & w_legal) |
                            (r_state == S_REQ) | (r_state == S_RESP));

endmodule
